// File: rtl/position_overlay_if.sv
// Coordinate load bus from the tracking/filtering pipeline into the overlay.
// The producer drives per-channel x/y/z with a load strobe, plus the marker shape.
interface position_overlay_if #(
    parameter int NUM_CH  = 2,
    parameter int COORD_W = 16
);
    logic [NUM_CH*COORD_W-1:0] x_in;
    logic [NUM_CH*COORD_W-1:0] y_in;
    logic [NUM_CH*COORD_W-1:0] z_in;
    logic [NUM_CH-1:0]         coord_valid;
    logic [1:0]                mode;

    modport master (output x_in, y_in, z_in, coord_valid, mode);
    modport slave  (input  x_in, y_in, z_in, coord_valid, mode);
endinterface

// File: rtl/position_overlay.sv
// VGA timing generator with one depth-scaled marker per tracked point.
// Pipeline: stage 0 counters -> stage 1 hit test -> stage 2 colour/output regs.
// Coordinates are double-buffered and swapped at the start of vertical blanking.
module position_overlay #(
    parameter int NUM_CH    = 2,
    parameter int COORD_W   = 16,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BASE_HALF = 4,
    parameter int Z_SHIFT   = 6,
    parameter int MAX_HALF  = 31,
    // channel 0 (red) occupies the least-significant 24 bits
    parameter logic [NUM_CH*24-1:0] COLORS = {24'h00FF00, 24'hFF0000}
) (
    input  logic              clock,
    input  logic              reset,
    position_overlay_if.slave coord_bus,
    output logic [10:0]       hcount,
    output logic [9:0]        vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic [23:0]       rgb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    // two spare bits: one for sign of dx/dy, one so BASE_HALF + z>>Z_SHIFT cannot overflow
    localparam int DW = COORD_W + 2;
    localparam logic [DW-1:0] BASE_D = DW'(BASE_HALF);
    localparam logic [DW-1:0] MAX_D  = DW'(MAX_HALF);

    // ---------------- stage 0: raster counters ----------------
    logic [10:0] hc_reg;
    logic [9:0]  vc_reg;
    logic        hsync_s0, vsync_s0, blank_s0, xfer;

    // Free-running pixel/line counters; line advances when the pixel counter wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            hc_reg <= '0;
            vc_reg <= '0;
        end else if (hc_reg == H_LAST) begin
            hc_reg <= '0;
            vc_reg <= (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
        end else begin
            hc_reg <= hc_reg + 11'd1;
        end
    end

    assign hsync_s0 = !((hc_reg >= HS_BEG) && (hc_reg < HS_END));
    assign vsync_s0 = !((vc_reg >= VS_BEG) && (vc_reg < VS_END));
    assign blank_s0 = (hc_reg >= H_ACT) || (vc_reg >= V_ACT);
    // first pixel of the first blanked line: swap shadow into active
    assign xfer     = (hc_reg == 11'd0) && (vc_reg == V_ACT);

    // ---------------- stage 1: timing delay + hit test ----------------
    logic [10:0] hc_s1_reg;
    logic [9:0]  vc_s1_reg;
    logic        hsync_s1_reg, vsync_s1_reg, blank_s1_reg;
    logic [NUM_CH-1:0] hit;

    // Carry the stage-0 raster position and syncs into the hit-test stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            hc_s1_reg    <= '0;
            vc_s1_reg    <= '0;
            hsync_s1_reg <= 1'b1;
            vsync_s1_reg <= 1'b1;
            blank_s1_reg <= 1'b1;
        end else begin
            hc_s1_reg    <= hc_reg;
            vc_s1_reg    <= vc_reg;
            hsync_s1_reg <= hsync_s0;
            vsync_s1_reg <= vsync_s0;
            blank_s1_reg <= blank_s0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [COORD_W-1:0] shadow_x_reg, shadow_y_reg, shadow_z_reg;
            logic [COORD_W-1:0] active_x_reg, active_y_reg, active_z_reg;
            logic               shadow_ok_reg, active_ok_reg;
            logic [DW-1:0]      half_sum, half, dx, dy, adx, ady;
            logic               in_box, ch_hit;

            // Shadow capture on load strobe; active copy updated only at the frame swap,
            // so a load on the swap cycle lands one frame later.
            always_ff @(posedge clock) begin
                if (reset) begin
                    shadow_x_reg  <= '0;
                    shadow_y_reg  <= '0;
                    shadow_z_reg  <= '0;
                    shadow_ok_reg <= 1'b0;
                    active_x_reg  <= '0;
                    active_y_reg  <= '0;
                    active_z_reg  <= '0;
                    active_ok_reg <= 1'b0;
                end else begin
                    if (coord_bus.coord_valid[gi]) begin
                        shadow_x_reg  <= coord_bus.x_in[gi*COORD_W +: COORD_W];
                        shadow_y_reg  <= coord_bus.y_in[gi*COORD_W +: COORD_W];
                        shadow_z_reg  <= coord_bus.z_in[gi*COORD_W +: COORD_W];
                        shadow_ok_reg <= 1'b1;
                    end
                    if (xfer) begin
                        active_x_reg  <= shadow_x_reg;
                        active_y_reg  <= shadow_y_reg;
                        active_z_reg  <= shadow_z_reg;
                        active_ok_reg <= shadow_ok_reg;
                    end
                end
            end

            assign half_sum = BASE_D + DW'(active_z_reg >> Z_SHIFT);
            assign half     = (half_sum > MAX_D) ? MAX_D : half_sum;
            assign dx       = DW'(hc_s1_reg) - DW'(active_x_reg);
            assign dy       = DW'(vc_s1_reg) - DW'(active_y_reg);
            assign adx      = dx[DW-1] ? -dx : dx;
            assign ady      = dy[DW-1] ? -dy : dy;
            assign in_box   = (adx <= half) && (ady <= half);

            // Shape decode for this channel, gated by having valid coordinates.
            always_comb begin
                ch_hit = 1'b0;
                case (coord_bus.mode)
                    2'd1:    ch_hit = in_box;
                    2'd2:    ch_hit = in_box && ((adx == half) || (ady == half));
                    2'd3:    ch_hit = ((dx == '0) && (ady <= half)) ||
                                      ((dy == '0) && (adx <= half));
                    default: ch_hit = 1'b0;
                endcase
                ch_hit = ch_hit && active_ok_reg;
            end

            assign hit[gi] = ch_hit;
        end
    endgenerate

    // ---------------- stage 2: colour select + outputs ----------------
    logic [23:0] rgb_next;

    // Lowest-index hitting channel wins; nothing is drawn inside blanking.
    always_comb begin
        rgb_next = 24'h0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) rgb_next = COLORS[i*24 +: 24];
        end
        if (blank_s1_reg) rgb_next = 24'h0;
    end

    logic [10:0] hcount_reg;
    logic [9:0]  vcount_reg;
    logic        hsync_reg, vsync_reg, blank_reg;
    logic [23:0] rgb_reg;

    // Output register: all six outputs share the same two-cycle delay.
    always_ff @(posedge clock) begin
        if (reset) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
            hsync_reg  <= 1'b1;
            vsync_reg  <= 1'b1;
            blank_reg  <= 1'b1;
            rgb_reg    <= '0;
        end else begin
            hcount_reg <= hc_s1_reg;
            vcount_reg <= vc_s1_reg;
            hsync_reg  <= hsync_s1_reg;
            vsync_reg  <= vsync_s1_reg;
            blank_reg  <= blank_s1_reg;
            rgb_reg    <= rgb_next;
        end
    end

    assign hcount = hcount_reg;
    assign vcount = vcount_reg;
    assign hsync  = hsync_reg;
    assign vsync  = vsync_reg;
    assign blank  = blank_reg;
    assign rgb    = rgb_reg;
endmodule
